// File: rtl/rsa_xcel_naive_pkg.sv
// Shared definitions for the naive modular-exponentiation sequencer:
// FSM state encoding and the {n, a, b} field layout used by MulRem requests.
package rsa_xcel_naive_pkg;

    localparam int P_NBITS = 32;
    localparam int MSG_W   = 3 * P_NBITS;

    // Field offsets inside a 3*P_NBITS message: {n, a, b} / {n, base, exp}
    localparam int N_LSB = 2 * P_NBITS;
    localparam int A_LSB = P_NBITS;
    localparam int B_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        WAIT_MUL,
        SQR,
        WAIT_SQR,
        DONE
    } state_t;

endpackage

// File: rtl/rsa_xcel_naive_mod_exp_if.sv
// Bundles the input stream, result stream and MulRem request/response
// channels of the modular-exponentiation sequencer.
// slave  : the sequencer itself.
// master : its surroundings (producer, consumer and the MulRem stage).
interface rsa_xcel_naive_mod_exp_if #(
    parameter int p_nbits = 32
);

    logic [3*p_nbits-1:0] istream_msg;
    logic                 istream_val;
    logic                 istream_rdy;

    logic [p_nbits-1:0]   ostream_msg;
    logic                 ostream_val;
    logic                 ostream_rdy;

    logic [3*p_nbits-1:0] mr_req_msg;
    logic                 mr_req_val;
    logic                 mr_req_rdy;

    logic [p_nbits-1:0]   mr_resp_msg;
    logic                 mr_resp_val;
    logic                 mr_resp_rdy;

    modport slave (
        input  istream_msg, istream_val,
        output istream_rdy,
        output ostream_msg, ostream_val,
        input  ostream_rdy,
        output mr_req_msg, mr_req_val,
        input  mr_req_rdy,
        input  mr_resp_msg, mr_resp_val,
        output mr_resp_rdy
    );

    modport master (
        output istream_msg, istream_val,
        input  istream_rdy,
        input  ostream_msg, ostream_val,
        output ostream_rdy,
        input  mr_req_msg, mr_req_val,
        output mr_req_rdy,
        output mr_resp_msg, mr_resp_val,
        input  mr_resp_rdy
    );

endinterface

// File: rtl/rsa_xcel_naive_mod_exp.sv
// Right-to-left square-and-multiply sequencer. Computes base^exp mod n by
// issuing one {n, a, b} request at a time to an external MulRem stage and
// emits the final residue. The square after the last multiply is skipped.
module rsa_xcel_naive_mod_exp
    import rsa_xcel_naive_pkg::*;
#(
    parameter int p_nbits = P_NBITS
) (
    input  logic                    clk,
    input  logic                    reset,
    rsa_xcel_naive_mod_exp_if.slave io
);

    state_t state, state_nxt;

    logic [p_nbits-1:0] n_r;   // modulus
    logic [p_nbits-1:0] b_r;   // running square of the base
    logic [p_nbits-1:0] r_r;   // result accumulator
    logic [p_nbits-1:0] e_r;   // exponent bits not yet consumed

    logic [p_nbits-1:0] in_n, in_base, in_exp;
    logic [p_nbits-1:0] e_shift;
    logic [p_nbits-1:0] req_a;
    logic               n_trivial;

    logic istream_rdy, ostream_val, mr_req_val, mr_resp_rdy;

    assign {in_n, in_base, in_exp} = io.istream_msg;
    assign e_shift   = e_r >> 1;
    // Anything mod 0 or mod 1 is reported as 0 without touching MulRem
    assign n_trivial = (in_n < p_nbits'(2));

    // State register; async reset drops any in-flight request immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and Moore handshake outputs
    always_comb begin
        state_nxt   = state;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        mr_req_val  = 1'b0;
        mr_resp_rdy = 1'b0;
        req_a       = b_r;
        case (state)
            IDLE: begin
                istream_rdy = 1'b1;
                if (io.istream_val) begin
                    if (n_trivial || in_exp == '0) state_nxt = DONE;
                    else if (in_exp[0])            state_nxt = MUL;
                    else                           state_nxt = SQR;
                end
            end
            MUL: begin
                mr_req_val = 1'b1;
                req_a      = r_r;
                if (io.mr_req_rdy) state_nxt = WAIT_MUL;
            end
            WAIT_MUL: begin
                mr_resp_rdy = 1'b1;
                // No bits left above this one: the pending square is useless
                if (io.mr_resp_val) state_nxt = (e_shift == '0) ? DONE : SQR;
            end
            SQR: begin
                mr_req_val = 1'b1;
                if (io.mr_req_rdy) state_nxt = WAIT_SQR;
            end
            WAIT_SQR: begin
                mr_resp_rdy = 1'b1;
                if (io.mr_resp_val) state_nxt = e_shift[0] ? MUL : SQR;
            end
            DONE: begin
                ostream_val = 1'b1;
                if (io.ostream_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch and MulRem result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_r <= '0;
            b_r <= '0;
            r_r <= '0;
            e_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.istream_val) begin
                        n_r <= in_n;
                        b_r <= in_base;
                        e_r <= in_exp;
                        r_r <= n_trivial ? '0 : p_nbits'(1);
                    end
                end
                WAIT_MUL: begin
                    if (io.mr_resp_val) r_r <= io.mr_resp_msg;
                end
                WAIT_SQR: begin
                    if (io.mr_resp_val) begin
                        b_r <= io.mr_resp_msg;
                        e_r <= e_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.istream_rdy = istream_rdy;
    assign io.ostream_val = ostream_val;
    assign io.ostream_msg = r_r;
    assign io.mr_req_val  = mr_req_val;
    assign io.mr_req_msg  = {n_r, req_a, b_r};
    assign io.mr_resp_rdy = mr_resp_rdy;

endmodule

// File: tb/tb_rsa_xcel_naive_mod_exp.sv
// Directed bench for the modular-exponentiation sequencer. A behavioural
// MulRem responder answers requests; each test task checks its own results.
module tb_rsa_xcel_naive_mod_exp;
    import rsa_xcel_naive_pkg::*;

    logic clk;
    logic reset;

    rsa_xcel_naive_mod_exp_if #(.p_nbits(32)) io ();

    rsa_xcel_naive_mod_exp #(.p_nbits(32)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // MulRem responder state
    bit          stall_en = 1'b0;
    int          lat      = 0;
    int          req_cnt  = 0;
    bit          pending  = 1'b0;
    int          resp_wait = 0;
    logic [31:0] resp_q   = '0;
    bit          req_hold = 1'b0;
    logic [95:0] hold_msg = '0;
    logic [31:0] n_log [16];
    logic [31:0] a_log [16];
    logic [31:0] b_log [16];

    // Directed vectors: n, base, exp, expected result, expected MulRem requests
    logic [31:0] vn [8] = '{32'd497, 32'd7, 32'd1, 32'd11, 32'd1000, 32'd13, 32'd7,  32'd0};
    logic [31:0] vb [8] = '{32'd4,   32'd5, 32'd9, 32'd3,  32'd2,    32'd0,  32'd12, 32'd5};
    logic [31:0] ve [8] = '{32'd13,  32'd0, 32'd3, 32'd1,  32'd10,   32'd5,  32'd2,  32'd3};
    logic [31:0] vr [8] = '{32'd445, 32'd1, 32'd0, 32'd3,  32'd24,   32'd0,  32'd4,  32'd0};
    int          vq [8] = '{6, 0, 0, 1, 5, 4, 2, 0};

    // Hand-derived request operands for 4^13 mod 497
    logic [31:0] seq_a [6] = '{32'd1, 32'd4, 32'd16, 32'd4,   32'd256, 32'd30};
    logic [31:0] seq_b [6] = '{32'd4, 32'd4, 32'd16, 32'd256, 32'd256, 32'd429};

    // Behavioural MulRem: one outstanding request, optional latency and stalls
    initial begin : mulrem_model
        logic [31:0] fn, fa, fb;
        io.mr_req_rdy  = 1'b0;
        io.mr_resp_val = 1'b0;
        io.mr_resp_msg = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                pending        = 1'b0;
                resp_wait      = 0;
                req_hold       = 1'b0;
                io.mr_req_rdy  = 1'b0;
                io.mr_resp_val = 1'b0;
            end else begin
                if (pending) begin
                    n_cmp++;
                    if (io.mr_req_val !== 1'b0) begin
                        n_bad++;
                        $display("FAIL outstanding: mr_req_val=%b with a response pending, required 0", io.mr_req_val);
                    end
                end
                if (req_hold) begin
                    n_cmp++;
                    if (io.mr_req_val !== 1'b1 || io.mr_req_msg !== hold_msg) begin
                        n_bad++;
                        $display("FAIL req_stable: val=%b msg=%h, required val=1 msg=%h", io.mr_req_val, io.mr_req_msg, hold_msg);
                    end
                end
                if (pending) begin
                    if (resp_wait > 0) begin
                        resp_wait--;
                        io.mr_resp_val = 1'b0;
                    end else begin
                        io.mr_resp_val = stall_en ? 1'($urandom_range(0, 2) != 0) : 1'b1;
                        io.mr_resp_msg = resp_q;
                        if (io.mr_resp_val && io.mr_resp_rdy === 1'b1) pending = 1'b0;
                    end
                end else begin
                    io.mr_resp_val = 1'b0;
                end
                io.mr_req_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!pending && io.mr_req_val === 1'b1 && io.mr_req_rdy) begin
                    fn = io.mr_req_msg[N_LSB +: 32];
                    fa = io.mr_req_msg[A_LSB +: 32];
                    fb = io.mr_req_msg[B_LSB +: 32];
                    if (req_cnt < 16) begin
                        n_log[req_cnt] = fn;
                        a_log[req_cnt] = fa;
                        b_log[req_cnt] = fb;
                    end
                    req_cnt++;
                    resp_q    = (fn == 0) ? 32'd0 : 32'((64'(fa) * 64'(fb)) % 64'(fn));
                    pending   = 1'b1;
                    resp_wait = lat + (stall_en ? int'($urandom_range(0, 3)) : 0);
                    req_hold  = 1'b0;
                end else begin
                    req_hold = !pending && (io.mr_req_val === 1'b1);
                    hold_msg = io.mr_req_msg;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one operation and wait (bounded) until it is accepted
    task automatic send(input logic [31:0] n, input logic [31:0] b, input logic [31:0] e,
                        output bit timeout);
        io.istream_msg = {n, b, e};
        io.istream_val = 1'b1;
        req_cnt = 0;
        timeout = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (io.istream_rdy === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        io.istream_val = 1'b0;
    endtask

    // Collect one result, optionally stalling ostream_rdy; counts hold violations
    task automatic recv(input bit stall, output logic [31:0] val, output bit timeout,
                        output int unstable);
        bit          held;
        logic [31:0] prev;
        held     = 1'b0;
        prev     = '0;
        val      = 'x;
        timeout  = 1'b1;
        unstable = 0;
        for (int c = 0; c < 2000; c++) begin
            if (held && (io.ostream_val !== 1'b1 || io.ostream_msg !== prev)) unstable++;
            if (io.ostream_val === 1'b1) begin
                io.ostream_rdy = stall ? 1'($urandom_range(0, 2) == 0) : 1'b1;
                prev = io.ostream_msg;
                held = !io.ostream_rdy;
                if (io.ostream_rdy) begin
                    val     = io.ostream_msg;
                    timeout = 1'b0;
                    @(negedge clk);
                    break;
                end
            end else begin
                io.ostream_rdy = 1'b0;
                held = 1'b0;
            end
            @(negedge clk);
        end
        io.ostream_rdy = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (io.istream_rdy !== 1'b1) begin
            n_bad++; $display("FAIL reset_istream_rdy: got %b required 1", io.istream_rdy);
        end
        n_cmp++;
        if ({io.ostream_val, io.mr_req_val, io.mr_resp_rdy} !== 3'b000) begin
            n_bad++; $display("FAIL reset_vals: ostream_val/mr_req_val/mr_resp_rdy got %b required 000",
                              {io.ostream_val, io.mr_req_val, io.mr_resp_rdy});
        end
        n_cmp++;
        if (io.ostream_msg !== 32'd0) begin
            n_bad++; $display("FAIL reset_ostream_msg: got %0d required 0", io.ostream_msg);
        end
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        bit tos, tor;
        int unst;
        logic [31:0] got;
        for (int i = 0; i < 8; i++) begin
            send(vn[i], vb[i], ve[i], tos);
            recv(1'b0, got, tor, unst);
            n_cmp++;
            if (tos || tor || got !== vr[i]) begin
                n_bad++; $display("FAIL vec%0d_result: got %0d (timeout %b%b) required %0d", i, got, tos, tor, vr[i]);
            end
            n_cmp++;
            if (req_cnt !== vq[i]) begin
                n_bad++; $display("FAIL vec%0d_reqs: got %0d required %0d", i, req_cnt, vq[i]);
            end
            n_cmp++;
            if (io.istream_rdy !== 1'b1) begin
                n_bad++; $display("FAIL vec%0d_idle: istream_rdy got %b required 1", i, io.istream_rdy);
            end
        end
    endtask

    task automatic test_exp13_sequence();
        bit tos, tor;
        int unst;
        logic [31:0] got;
        send(32'd497, 32'd4, 32'd13, tos);
        recv(1'b0, got, tor, unst);
        n_cmp++;
        if (tos || tor || req_cnt !== 6) begin
            n_bad++; $display("FAIL seq_count: got %0d requests (timeout %b%b) required 6", req_cnt, tos, tor);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (n_log[i] !== 32'd497 || a_log[i] !== seq_a[i] || b_log[i] !== seq_b[i]) begin
                n_bad++; $display("FAIL seq_req%0d: got {%0d,%0d,%0d} required {497,%0d,%0d}",
                                  i, n_log[i], a_log[i], b_log[i], seq_a[i], seq_b[i]);
            end
        end
    endtask

    task automatic test_stalls();
        bit tos, tor;
        int unst;
        logic [31:0] got;
        int idx [4] = '{0, 4, 5, 6};
        stall_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int rep = 0; rep < 2; rep++) begin
                send(vn[idx[k]], vb[idx[k]], ve[idx[k]], tos);
                recv(1'b1, got, tor, unst);
                n_cmp++;
                if (tos || tor || got !== vr[idx[k]]) begin
                    n_bad++; $display("FAIL stall%0d_result: got %0d (timeout %b%b) required %0d", idx[k], got, tos, tor, vr[idx[k]]);
                end
                n_cmp++;
                if (req_cnt !== vq[idx[k]]) begin
                    n_bad++; $display("FAIL stall%0d_reqs: got %0d required %0d", idx[k], req_cnt, vq[idx[k]]);
                end
                n_cmp++;
                if (unst !== 0) begin
                    n_bad++; $display("FAIL stall%0d_ostream_hold: got %0d unstable cycles required 0", idx[k], unst);
                end
            end
        end
        stall_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit tos, tor, found;
        int unst;
        logic [31:0] got;
        lat = 6;
        send(32'd1000, 32'd2, 32'd10, tos);
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (io.mr_resp_rdy === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (tos || !found) begin
            n_bad++; $display("FAIL mid_reach_wait: reached WAIT_SQR %b required 1", found);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (io.istream_rdy !== 1'b1 || io.mr_resp_rdy !== 1'b0 || io.mr_req_val !== 1'b0 || io.ostream_val !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_ctrl: istream_rdy/mr_resp_rdy/mr_req_val/ostream_val got %b required 1000",
                              {io.istream_rdy, io.mr_resp_rdy, io.mr_req_val, io.ostream_val});
        end
        n_cmp++;
        if (io.ostream_msg !== 32'd0) begin
            n_bad++; $display("FAIL mid_reset_msg: got %0d required 0", io.ostream_msg);
        end
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        lat = 0;
        @(negedge clk);
        send(32'd1000, 32'd2, 32'd10, tos);
        recv(1'b0, got, tor, unst);
        n_cmp++;
        if (tos || tor || got !== 32'd24) begin
            n_bad++; $display("FAIL mid_next_result: got %0d (timeout %b%b) required 24", got, tos, tor);
        end
        n_cmp++;
        if (req_cnt !== 5) begin
            n_bad++; $display("FAIL mid_next_reqs: got %0d required 5", req_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit tor, seen;
        int unst;
        logic [31:0] got;
        io.istream_msg = {32'd11, 32'd3, 32'd1};
        io.istream_val = 1'b1;
        req_cnt = 0;
        for (int c = 0; c < 20 && io.istream_rdy !== 1'b1; c++) @(negedge clk);
        @(negedge clk);
        io.istream_msg = {32'd1000, 32'd2, 32'd10};
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (io.ostream_val === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!seen || io.istream_rdy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_done_blocks: ostream_val seen %b istream_rdy %b required 1 0", seen, io.istream_rdy);
        end
        @(negedge clk);
        n_cmp++;
        if (io.ostream_val !== 1'b1 || io.ostream_msg !== 32'd3 || io.istream_rdy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_hold: val %b msg %0d istream_rdy %b required 1 3 0",
                              io.ostream_val, io.ostream_msg, io.istream_rdy);
        end
        io.ostream_rdy = 1'b1;
        @(negedge clk);
        io.ostream_rdy = 1'b0;
        n_cmp++;
        if (io.istream_rdy !== 1'b1 || req_cnt !== 1) begin
            n_bad++; $display("FAIL b2b_first_done: istream_rdy %b reqs %0d required 1 1", io.istream_rdy, req_cnt);
        end
        req_cnt = 0;
        @(negedge clk);
        io.istream_val = 1'b0;
        n_cmp++;
        if (io.istream_rdy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_second_accept: istream_rdy got %b required 0", io.istream_rdy);
        end
        recv(1'b0, got, tor, unst);
        n_cmp++;
        if (tor || got !== 32'd24 || req_cnt !== 5) begin
            n_bad++; $display("FAIL b2b_second_result: got %0d reqs %0d (timeout %b) required 24 5", got, req_cnt, tor);
        end
    endtask

    initial begin
        io.istream_msg = '0;
        io.istream_val = 1'b0;
        io.ostream_rdy = 1'b0;
        reset = 1'b0;
        test_reset();
        test_exp13_sequence();
        test_vectors();
        test_stalls();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
